// File: rtl/rrat_nway.sv
// Retirement RAT: committed architectural-to-physical map updated by up to
// RETIRE_WIDTH retiring instructions per cycle; frees displaced tags and publishes the map on mispredict.
module rrat_nway #(
  parameter int ARF_SIZE     = 32,
  parameter int PRF_SIZE     = 64,
  parameter int RETIRE_WIDTH = 2,
  parameter bit ZERO_REG_EN  = 1'b1,
  localparam int AW = (ARF_SIZE > 1) ? $clog2(ARF_SIZE) : 1,
  localparam int PW = (PRF_SIZE > 1) ? $clog2(PRF_SIZE) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [RETIRE_WIDTH-1:0]    RoB_rename_in,
  input  logic [RETIRE_WIDTH*AW-1:0] RoB_ARF_idx,
  input  logic [RETIRE_WIDTH*PW-1:0] RoB_PRF_idx,
  input  logic                       mispredict_sig,
  output logic [RETIRE_WIDTH-1:0]    PRF_free_valid,
  output logic [RETIRE_WIDTH*PW-1:0] PRF_free_idx,
  output logic [ARF_SIZE-1:0]        mispredict_up_valid,
  output logic [ARF_SIZE*PW-1:0]     mispredict_up_idx
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(ARF_SIZE - 1);

  logic [PW-1:0]              map_q [ARF_SIZE];
  logic [PW-1:0]              map_d [ARF_SIZE];
  logic [ARF_SIZE-1:0]        vld_q, vld_d;
  logic [RETIRE_WIDTH-1:0]    free_valid_q, free_valid_d;
  logic [RETIRE_WIDTH*PW-1:0] free_idx_q, free_idx_d;
  logic [ARF_SIZE-1:0]        up_valid_q, up_valid_d;
  logic [ARF_SIZE*PW-1:0]     up_idx_q, up_idx_d;

  logic [AW-1:0] lane_arf [RETIRE_WIDTH];
  logic [PW-1:0] lane_prf [RETIRE_WIDTH];

  for (genvar gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_lane
    assign lane_arf[gi] = RoB_ARF_idx[gi*AW +: AW];
    assign lane_prf[gi] = RoB_PRF_idx[gi*PW +: PW];
  end

  // Lanes are applied oldest-first to a working copy of the map, so a younger
  // lane hitting the same ARF sees (and frees) the older lane's new tag.
  always_comb begin
    vld_d        = vld_q;
    free_valid_d = '0;
    free_idx_d   = '0;
    up_valid_d   = '0;
    up_idx_d     = '0;
    for (int i = 0; i < ARF_SIZE; i++) begin
      map_d[i] = map_q[i];
    end
    for (int l = 0; l < RETIRE_WIDTH; l++) begin
      if (RoB_rename_in[l]) begin
        if (ZERO_REG_EN && lane_arf[l] == ZERO_IDX) begin
          free_valid_d[l]          = 1'b1;
          free_idx_d[l*PW +: PW]   = lane_prf[l];
        end else if (32'(lane_arf[l]) < ARF_SIZE) begin
          if (vld_d[lane_arf[l]]) begin
            free_valid_d[l]        = 1'b1;
            free_idx_d[l*PW +: PW] = map_d[lane_arf[l]];
          end
          map_d[lane_arf[l]] = lane_prf[l];
          vld_d[lane_arf[l]] = 1'b1;
        end
      end
    end
    if (mispredict_sig) begin
      up_valid_d = vld_d;
      for (int i = 0; i < ARF_SIZE; i++) begin
        up_idx_d[i*PW +: PW] = map_d[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ARF_SIZE; i++) begin
        map_q[i] <= '0;
      end
      vld_q        <= '0;
      free_valid_q <= '0;
      free_idx_q   <= '0;
      up_valid_q   <= '0;
      up_idx_q     <= '0;
    end else begin
      for (int i = 0; i < ARF_SIZE; i++) begin
        map_q[i] <= map_d[i];
      end
      vld_q        <= vld_d;
      free_valid_q <= free_valid_d;
      free_idx_q   <= free_idx_d;
      up_valid_q   <= up_valid_d;
      up_idx_q     <= up_idx_d;
    end
  end

  assign PRF_free_valid      = free_valid_q;
  assign PRF_free_idx        = free_idx_q;
  assign mispredict_up_valid = up_valid_q;
  assign mispredict_up_idx   = up_idx_q;

endmodule

// File: tb/tb_rrat_nway.sv
// Directed bench for rrat_nway (32 ARF, 64 PRF, 2 lanes, zero reg enabled).
module tb_rrat_nway;

  logic         clock;
  logic         reset;
  logic [1:0]   RoB_rename_in;
  logic [9:0]   RoB_ARF_idx;
  logic [11:0]  RoB_PRF_idx;
  logic         mispredict_sig;
  logic [1:0]   PRF_free_valid;
  logic [11:0]  PRF_free_idx;
  logic [31:0]  mispredict_up_valid;
  logic [191:0] mispredict_up_idx;

  int tests  = 0;
  int failed = 0;

  logic [191:0] exp_up;

  rrat_nway #(
    .ARF_SIZE(32), .PRF_SIZE(64), .RETIRE_WIDTH(2), .ZERO_REG_EN(1'b1)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .RoB_rename_in      (RoB_rename_in),
    .RoB_ARF_idx        (RoB_ARF_idx),
    .RoB_PRF_idx        (RoB_PRF_idx),
    .mispredict_sig     (mispredict_sig),
    .PRF_free_valid     (PRF_free_valid),
    .PRF_free_idx       (PRF_free_idx),
    .mispredict_up_valid(mispredict_up_valid),
    .mispredict_up_idx  (mispredict_up_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample just after the capturing edge.
  task automatic step(input logic rst, input logic [1:0] v,
                      input logic [4:0] a0, input logic [5:0] p0,
                      input logic [4:0] a1, input logic [5:0] p1,
                      input logic mp);
    reset          = rst;
    RoB_rename_in  = v;
    RoB_ARF_idx    = {a1, a0};
    RoB_PRF_idx    = {p1, p0};
    mispredict_sig = mp;
    @(posedge clock);
    #1;
    $display("[TB] t=%0t rst=%0b v=%b a0=%0d p0=%0d a1=%0d p1=%0d mp=%0b -> fv=%b fidx=%h upv=%h",
             $time, rst, v, a0, p0, a1, p1, mp, PRF_free_valid, PRF_free_idx, mispredict_up_valid);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_fv"},  192'(PRF_free_valid), 192'(0));
    chk({tag, "_fi"},  192'(PRF_free_idx), 192'(0));
    chk({tag, "_upv"}, 192'(mispredict_up_valid), 192'(0));
    chk({tag, "_upi"}, mispredict_up_idx, 192'(0));
  endtask

  initial begin
    reset = 1'b1; RoB_rename_in = '0; RoB_ARF_idx = '0; RoB_PRF_idx = '0; mispredict_sig = 1'b0;

    step(1'b1, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0);
    chk_idle("reset");

    step(1'b0, 2'b11, 5'd0, 6'd2, 5'd1, 6'd3, 1'b0);
    chk("first_fv", 192'(PRF_free_valid), 192'(2'b00));
    chk("first_fi", 192'(PRF_free_idx), 192'(0));

    step(1'b0, 2'b01, 5'd0, 6'd7, 5'd0, 6'd0, 1'b0);
    chk("a0p7_fv", 192'(PRF_free_valid), 192'(2'b01));
    chk("a0p7_fi", 192'(PRF_free_idx), 192'({6'd0, 6'd2}));

    step(1'b0, 2'b01, 5'd0, 6'd8, 5'd0, 6'd0, 1'b0);
    chk("a0p8_fv", 192'(PRF_free_valid), 192'(2'b01));
    chk("a0p8_fi", 192'(PRF_free_idx), 192'({6'd0, 6'd7}));

    step(1'b0, 2'b11, 5'd1, 6'd10, 5'd1, 6'd11, 1'b0);
    chk("conf_fv", 192'(PRF_free_valid), 192'(2'b11));
    chk("conf_fi", 192'(PRF_free_idx), 192'({6'd10, 6'd3}));

    step(1'b0, 2'b10, 5'd0, 6'd0, 5'd31, 6'd20, 1'b0);
    chk("zero_fv", 192'(PRF_free_valid), 192'(2'b10));
    chk("zero_fi", 192'(PRF_free_idx), 192'({6'd20, 6'd0}));
    chk("zero_upv", 192'(mispredict_up_valid), 192'(0));

    exp_up = '0;
    exp_up[5:0]   = 6'd8;
    exp_up[11:6]  = 6'd11;
    exp_up[17:12] = 6'd9;
    step(1'b0, 2'b01, 5'd2, 6'd9, 5'd0, 6'd0, 1'b1);
    chk("mp_upv", 192'(mispredict_up_valid), 192'(32'h7));
    chk("mp_upi", mispredict_up_idx, exp_up);
    chk("mp_fv",  192'(PRF_free_valid), 192'(2'b00));

    step(1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0);
    chk_idle("post_mp");

    step(1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b1);
    chk("mp2_upv", 192'(mispredict_up_valid), 192'(32'h7));
    chk("mp2_upi", mispredict_up_idx, exp_up);
    step(1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b1);
    chk("mp3_upv", 192'(mispredict_up_valid), 192'(32'h7));
    chk("mp3_upi", mispredict_up_idx, exp_up);

    step(1'b1, 2'b01, 5'd0, 6'd12, 5'd0, 6'd0, 1'b1);
    chk_idle("rst_mid");

    step(1'b0, 2'b01, 5'd0, 6'd13, 5'd0, 6'd0, 1'b0);
    chk("after_rst_fv", 192'(PRF_free_valid), 192'(2'b00));
    chk("after_rst_fi", 192'(PRF_free_idx), 192'(0));

    exp_up = '0;
    exp_up[5:0] = 6'd13;
    step(1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b1);
    chk("after_rst_upv", 192'(mispredict_up_valid), 192'(32'h1));
    chk("after_rst_upi", mispredict_up_idx, exp_up);

    step(1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0);
    chk_idle("final");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
